uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning soc_clk cycles per UART bit (10 MHz / 115200 baud); legal range 16..65535.
REQ-002 SHALL have parameter FIFO_AW, default 3, meaning FIFO address width, depth 2**FIFO_AW = 8 bytes.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port rx_i, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port rd_data_o, output, 8 bits: head-of-FIFO byte, meaningful only while rd_valid_o=1.
REQ-007 SHALL have port rd_valid_o, output, 1 bit: FIFO non-empty.
REQ-008 SHALL have port rd_ready_i, input, 1 bit: consumer accepts the head byte when rd_valid_o=1.
REQ-009 SHALL have port frame_err_o, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overrun_o, output, 1 bit: one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-011 SHALL have port level_o, output, FIFO_AW+1 bits: current FIFO occupancy, 0..2**FIFO_AW.

Function
REQ-012 SHALL pass rx_i through a 2-flop synchronizer; all decoding uses the second flop (rx_s) plus one delayed copy (rx_d) for edge detection.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 In IDLE, SHALL go to START on rx_d=1 and rx_s=0, loading the bit counter with CLKS_PER_BIT/2-1 (integer division).
REQ-015 In START, when the counter reaches 0, SHALL sample rx_s: 0 goes to DATA with counter CLKS_PER_BIT-1 and bit index 0; 1 is a glitch and returns to IDLE with no push and no flag.
REQ-016 In DATA, each time the counter reaches 0, SHALL shift rx_s into bit[index], reload CLKS_PER_BIT-1, and increment the index; after bit 7 is sampled, SHALL go to STOP.
REQ-017 In STOP, when the counter reaches 0, SHALL sample rx_s: 1 means the byte is complete and the FSM goes to IDLE; 0 pulses frame_err_o for one cycle, discards the byte, and goes to WAIT_HIGH.
REQ-018 WAIT_HIGH SHALL remain until rx_s=1, then go to IDLE; line breaks of any length SHALL produce exactly one frame_err_o pulse.
REQ-019 A completed byte SHALL be written into the FIFO on the cycle after the stop-bit sample; rd_valid_o and level_o SHALL reflect it one cycle after the write, with no empty-FIFO bypass.
REQ-020 A completed byte arriving while level_o = 2**FIFO_AW and no pop occurs SHALL be dropped and SHALL pulse overrun_o in the write cycle; FIFO contents SHALL be unchanged.
REQ-021 A write and a pop in the same cycle while full SHALL both succeed, with no overrun and level unchanged.
REQ-022 The FIFO SHALL be first-word-fall-through: rd_data_o is the oldest byte; a pop (rd_valid_o & rd_ready_i) advances the head next cycle; rd_ready_i while empty SHALL be ignored.
REQ-023 Simultaneous write and pop while non-full and non-empty SHALL leave level_o unchanged; pointers SHALL wrap modulo 2**FIFO_AW.
REQ-024 A new start edge SHALL be accepted in IDLE immediately after a valid stop sample, so back-to-back frames with one stop bit are received.

Reset
REQ-025 While rst_n_i=0 at a clock edge: synchronizer flops and rx_d SHALL be 1; FSM SHALL be IDLE; counters, pointers, and the shift register SHALL be 0.
REQ-026 Output reset values SHALL be rd_valid_o=0, level_o=0, frame_err_o=0, overrun_o=0, rd_data_o=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no push and no flag; after release, the first start edge SHALL begin a new frame.

Verification
REQ-028 With rd_ready_i=0, drive frame 0xA5 at 87 cycles/bit: rd_data_o=0xA5, rd_valid_o=1, level_o=1 within 2 cycles after the stop-bit midpoint; no flags.
REQ-029 Drive rx_i low for 20 cycles, then high: no byte, no flags, FSM back in IDLE.
REQ-030 Drive 0x3C with stop bit low, held low 500 cycles, then high, then a valid 0x81: exactly one frame_err_o pulse, 0x3C never appears, 0x81 received.
REQ-031 Send 9 back-to-back bytes 0x00..0x08 with rd_ready_i=0: one overrun_o pulse on the 9th; level_o=8; draining returns 0x00..0x07 in order.
REQ-032 Assert rst_n_i for 1 cycle during bit 4 of a frame, then send 0x5A: only 0x5A received, level_o=1.
REQ-033 With FIFO full, pop on the exact write cycle of a new byte: no overrun, level_o stays 8, new byte appears last in the drain order.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a first-word-fall-through byte FIFO.
// Frame errors and FIFO overruns are reported as single-cycle pulses.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned FIFO_AW      = 3
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             rx_i,
  output logic [7:0]       rd_data_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic             frame_err_o,
  output logic             overrun_o,
  output logic [FIFO_AW:0] level_o
);

  localparam int unsigned Depth   = 2 ** FIFO_AW;
  localparam int unsigned HalfInt = CLKS_PER_BIT / 2 - 1;
  localparam int unsigned FullInt = CLKS_PER_BIT - 1;
  localparam logic [15:0] HalfBit = HalfInt[15:0];
  localparam logic [15:0] FullBit = FullInt[15:0];
  localparam logic [FIFO_AW-1:0] PtrOne  = 1;
  localparam logic [FIFO_AW:0]   CntOne  = 1;
  localparam logic [FIFO_AW:0]   CntFull = Depth[FIFO_AW:0];

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

  logic rx_meta_q, rx_s_q, rx_d_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
    end
  end

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        push_q, push_d;
  logic        frame_err_q, frame_err_d;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_d_q && !rx_s_q) begin
          state_d = StStart;
          cnt_d   = HalfBit;
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          if (!rx_s_q) begin
            state_d = StData;
            cnt_d   = FullBit;
            idx_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = FullBit;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          if (rx_s_q) begin
            push_d  = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StWaitHigh: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // The byte stays stable in shift_q during the write cycle: DATA is many cycles away.
  logic [7:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               full, pop, wr_en;

  assign full  = (count_q == CntFull);
  assign pop   = (count_q != '0) && rd_ready_i;
  assign wr_en = push_q && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + CntOne;
    else if (!wr_en && pop) count_d = count_q - CntOne;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)   rd_ptr_q <= rd_ptr_q + PtrOne;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rd_valid_o  = (count_q != '0);
  assign rd_data_o   = rd_valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign level_o     = count_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = push_q && full && !pop;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: reception, glitch rejection, frame error,
// overrun, mid-frame reset and full-FIFO simultaneous write/pop.
module tb_uart_rx_fifo;

  localparam int Bit = 87;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       frame_err;
  logic       overrun;
  logic [3:0] level;

  int n_tests = 0;
  int n_fail  = 0;
  int fe_cnt  = 0;
  int ov_cnt  = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT(Bit),
    .FIFO_AW     (3)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .rx_i       (rx),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid),
    .rd_ready_i (rd_ready),
    .frame_err_o(frame_err),
    .overrun_o  (overrun),
    .level_o    (level)
  );

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (Bit) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (Bit) @(negedge clk);
    end
    rx = stop;
    repeat (Bit) @(negedge clk);
  endtask

  task automatic check_level(input logic [3:0] exp, input string name);
    n_tests++;
    if (level !== exp) begin
      n_fail++;
      $display("FAIL %s: level_o=%0d expected %0d", name, level, exp);
    end
  endtask

  task automatic check_count(input int got, input int exp, input string name);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: pulse count=%0d expected %0d", name, got, exp);
    end
  endtask

  // Checks the head byte then pops it.
  task automatic pop_check(input logic [7:0] exp, input string name);
    n_tests++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      n_fail++;
      $display("FAIL %s: rd_valid_o=%b rd_data_o=%h expected 1/%h", name, rd_valid, rd_data, exp);
    end
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b data=%h ferr=%b ovr=%b expected 0/00/0/0",
               rd_valid, rd_data, frame_err, overrun);
    end
    check_level(4'd0, "reset_level");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_level(4'd0, "post_reset_level");
  endtask

  task automatic test_single;
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    send_frame(8'hA5, 1'b1);
    check_level(4'd1, "single_level");
    check_count(fe_cnt - fe0, 0, "single_no_ferr");
    check_count(ov_cnt - ov0, 0, "single_no_ovr");
    pop_check(8'hA5, "single_data");
    n_tests++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_empty: rd_valid_o=%b expected 0", rd_valid);
    end
    check_level(4'd0, "single_drained");
    // rd_ready while empty must be ignored.
    rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    rd_ready = 1'b0;
    check_level(4'd0, "empty_pop_ignored");
  endtask

  task automatic test_glitch;
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check_level(4'd0, "glitch_no_byte");
    check_count(fe_cnt - fe0, 0, "glitch_no_ferr");
    check_count(ov_cnt - ov0, 0, "glitch_no_ovr");
    send_frame(8'h42, 1'b1);
    check_level(4'd1, "glitch_then_frame_level");
    pop_check(8'h42, "glitch_then_frame_data");
  endtask

  task automatic test_frame_err;
    int fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (500) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    send_frame(8'h81, 1'b1);
    check_count(fe_cnt - fe0, 1, "break_single_ferr");
    check_level(4'd1, "ferr_level");
    pop_check(8'h81, "ferr_next_byte");
    check_level(4'd0, "ferr_drained");
  endtask

  task automatic test_overrun;
    int ov0 = ov_cnt;
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1);
    check_count(ov_cnt - ov0, 1, "overrun_pulse");
    check_level(4'd8, "overrun_level");
    for (int i = 0; i < 8; i++) pop_check(8'(i), "overrun_drain");
    check_level(4'd0, "overrun_drained");
  endtask

  task automatic test_mid_reset;
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    rx = 1'b0;
    repeat (Bit) @(negedge clk);
    rx = 1'b1;
    repeat (4 * Bit + 40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (600) @(negedge clk);
    check_level(4'd0, "midreset_aborted");
    send_frame(8'h5A, 1'b1);
    check_level(4'd1, "midreset_level");
    check_count(fe_cnt - fe0, 0, "midreset_no_ferr");
    check_count(ov_cnt - ov0, 0, "midreset_no_ovr");
    pop_check(8'h5A, "midreset_data");
  endtask

  task automatic test_full_pop;
    int ov0;
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1);
    check_level(4'd8, "fullpop_filled");
    ov0 = ov_cnt;
    // Stop sample lands on the 829th rising edge after the start bit begins; write is the next.
    fork
      send_frame(8'h99, 1'b1);
      begin
        repeat (829) @(negedge clk);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
      end
    join
    check_count(ov_cnt - ov0, 0, "fullpop_no_ovr");
    check_level(4'd8, "fullpop_level");
    for (int i = 1; i < 8; i++) pop_check(8'h10 + 8'(i), "fullpop_drain");
    pop_check(8'h99, "fullpop_new_last");
    check_level(4'd0, "fullpop_drained");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_mid_reset();
    test_full_pop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
